// File: rtl/ttl_gate_bank.sv
// ttl_gate_bank: CHANNELS two-input gates, function picked by a debounced mode button, results on even LEDs.
// Optional macro GATE_BANK_FREEZE_EN adds a freeze_btn that toggles a hold on the LED register.
module ttl_gate_bank #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CHANNELS-1:0] sw_pin,
  input  logic                  btn_mode,
`ifdef GATE_BANK_FREEZE_EN
  input  logic                  freeze_btn,
`endif
  output logic [2*CHANNELS-1:0] led_pin,
  output logic [2:0]            mode_led
);

  localparam int NSW = 2 * CHANNELS;
`ifdef GATE_BANK_FREEZE_EN
  localparam int NIN = NSW + 2;
`else
  localparam int NIN = NSW + 1;
`endif
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    M_NAND = 3'd0,
    M_NOR  = 3'd1,
    M_AND  = 3'd2,
    M_OR   = 3'd3,
    M_XOR  = 3'd4,
    M_XNOR = 3'd5
  } mode_e;

  logic [NIN-1:0]         raw;
  logic [NIN-1:0]         sync1_q, sync2_q;
  logic [NIN-1:0]         stable_q, stable_d;
  logic [NIN-1:0][CW-1:0] cnt_q, cnt_d;
  logic                   btn_prev_q, btn_prev_d;
  logic                   btn_rise;
  mode_e                  mode_q, mode_d;
  logic [NSW-1:0]         led_q, led_d;
  logic                   frozen;

`ifdef GATE_BANK_FREEZE_EN
  logic frz_prev_q, frz_prev_d;
  logic freeze_q, freeze_d;

  assign raw    = {freeze_btn, btn_mode, sw_pin};
  assign frozen = freeze_q;

  always_comb begin
    frz_prev_d = stable_q[NIN-1];
    freeze_d   = freeze_q ^ (stable_q[NIN-1] & ~frz_prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz_prev_q <= 1'b0;
      freeze_q   <= 1'b0;
    end else begin
      frz_prev_q <= frz_prev_d;
      freeze_q   <= freeze_d;
    end
  end
`else
  assign raw    = {btn_mode, sw_pin};
  assign frozen = 1'b0;
`endif

  // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    btn_prev_d = stable_q[NSW];
    btn_rise   = stable_q[NSW] & ~btn_prev_q;
    mode_d     = mode_q;
    case (mode_q)
      M_NAND:  mode_d = btn_rise ? M_NOR  : M_NAND;
      M_NOR:   mode_d = btn_rise ? M_AND  : M_NOR;
      M_AND:   mode_d = btn_rise ? M_OR   : M_AND;
      M_OR:    mode_d = btn_rise ? M_XOR  : M_OR;
      M_XOR:   mode_d = btn_rise ? M_XNOR : M_XOR;
      M_XNOR:  mode_d = btn_rise ? M_NAND : M_XNOR;
      default: mode_d = M_NAND;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (!frozen) begin
      led_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        case (mode_q)
          M_NAND:  led_d[2*k] = ~(stable_q[2*k] & stable_q[2*k+1]);
          M_NOR:   led_d[2*k] = ~(stable_q[2*k] | stable_q[2*k+1]);
          M_AND:   led_d[2*k] = stable_q[2*k] & stable_q[2*k+1];
          M_OR:    led_d[2*k] = stable_q[2*k] | stable_q[2*k+1];
          M_XOR:   led_d[2*k] = stable_q[2*k] ^ stable_q[2*k+1];
          M_XNOR:  led_d[2*k] = ~(stable_q[2*k] ^ stable_q[2*k+1]);
          default: led_d[2*k] = ~(stable_q[2*k] & stable_q[2*k+1]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      btn_prev_q <= 1'b0;
      mode_q     <= M_NAND;
      led_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
    end
  end

  assign led_pin  = led_q;
  assign mode_led = mode_q;

endmodule

// File: doc/ttl_gate_bank.md
# ttl_gate_bank

Parametrised successor to the fixed quad-NAND switch/LED block on the EGO1 board. It implements CHANNELS two-input gates whose function is selected at run time by a mode button: NAND, NOR, AND, OR, XOR or XNOR. All switch and button inputs are synchronised and debounced. Gate results are registered onto the even-indexed LEDs.

## Interface
- CHANNELS, default 4: number of two-input gates; legal range 1..8.
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept an input change (10 ms at 100 MHz); minimum 1.
- clk  input  1: system clock; all state on rising edge.
- rst  input  1: asynchronous, active-high reset.
- sw_pin  input  2*CHANNELS: raw switches; gate k inputs are sw_pin[2k] and sw_pin[2k+1].
- btn_mode  input  1: raw push button; each debounced press advances the mode.
- led_pin  output  2*CHANNELS: led_pin[2k] is gate k result; odd bits are tied 0.
- mode_led  output  3: current mode code.
- freeze_btn  input  1: present only with GATE_BANK_FREEZE_EN; raw freeze toggle button.

## Operation
- Input path:
  - Every raw input bit (sw_pin, btn_mode, freeze_btn) passes a 2-FF synchroniser and then a per-bit debouncer.
  - Each debouncer holds a registered stable value and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When the synchronised bit equals stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the bit still differs, stable takes the new value on the next edge and the counter clears.
  - Any excursion shorter than DEBOUNCE_CYCLES cycles is discarded.
- Mode FSM:
  - States and mode_led codes: NAND=0, NOR=1, AND=2, OR=3, XOR=4, XNOR=5.
  - A rising edge of the stable btn_mode value (stable high, previous-cycle copy low) advances the state by one.
  - XNOR wraps to NAND. Codes 6 and 7 are unreachable; if ever reached, the next edge returns the FSM to NAND.
  - Holding the button produces exactly one step. Release produces no step.
- Output:
  - Each cycle, led_pin[2k] is registered with f(stable sw[2k], stable sw[2k+1]) using the current mode.
  - A switch change and a mode step landing in the same cycle combine naturally: the next output uses both new values.
- Reset:
  - Clears all synchronisers, debouncer stable values and counters, the edge-detect flop and the freeze state.
  - Mode goes to NAND. led_pin=0 and mode_led=0 while rst is high.
  - Asserting reset mid-debounce discards the pending change entirely; no late update follows release.

## Timing
- After rst releases, the first clock edge loads led_pin with the NAND of all-zero inputs, so the even bits become 1.
- Switch change to led_pin: DEBOUNCE_CYCLES+3 cycles (2 sync, DEBOUNCE_CYCLES debounce, 1 output register).
- Button press to mode_led: DEBOUNCE_CYCLES+3 cycles.
- Button press to led_pin showing the new function: DEBOUNCE_CYCLES+4 cycles.
- With DEBOUNCE_CYCLES=1, switch latency is 3 cycles.
- No handshakes. Inputs are fully asynchronous to clk.

## Configuration
- GATE_BANK_FREEZE_EN defined:
  - Adds freeze_btn with its own synchroniser, debouncer and edge detector.
  - Each debounced press toggles a freeze flag; reset clears it.
  - While frozen, the led_pin register holds its value.
  - Switch debouncers and the mode FSM keep running, and mode_led still updates.
  - On unfreeze, led_pin reflects the current inputs and mode on the next edge.
- GATE_BANK_FREEZE_EN undefined: no freeze_btn port and no freeze logic; led_pin always tracks its inputs.

## Test plan
All scenarios use CHANNELS=4 and DEBOUNCE_CYCLES=4.
- Reset: rst high gives led_pin=8'h00 and mode_led=0. First edge after release gives led_pin=8'h55.
- Switch latency: sw_pin=8'hFF held from cycle 0 gives led_pin=8'h55 through cycle 6 and 8'h00 from the edge 7 cycles later.
- Glitch rejection: sw_pin[0] pulsed high for 3 cycles leaves led_pin unchanged. A 4-cycle pulse in the middle of a longer hold is accepted.
- Mode sweep: with sw_pin=8'h1B, six presses (each held ≥6 cycles, released ≥6 cycles) must give mode_led and led_pin as follows:
  - NAND 0 → 8'h54; NOR 1 → 8'h40; AND 2 → 8'h01; OR 3 → 8'h15; XOR 4 → 8'h14; XNOR 5 → 8'h41.
  - The sixth press wraps back to 0 → 8'h54.
- Reset mid-debounce: change sw_pin to 8'hFF, assert rst 2 cycles later and release after 1 cycle. Outputs must be 0 during reset and then 8'h55; sw_pin then needs a full 7-cycle latency before led_pin changes.
- Freeze (GATE_BANK_FREEZE_EN):
  - Press freeze, then set sw_pin=8'hFF and press mode once: led_pin holds 8'h55 while mode_led becomes 1.
  - Press freeze again: led_pin becomes 8'h00 (NOR of 1,1) one edge after the toggle.
